// File: rtl/scratchpad_types_pkg.sv
// Shared scratchpad types and constants.
//   w_state_t    : write-channel FSM states
//   scpad_addr_t : scratchpad row address
//   scpad_data_t : scratchpad row payload
package scratchpad_types_pkg;
  localparam int SCPAD_ADDR_W = 16;
  localparam int SCPAD_DATA_W = 128;

  typedef logic [SCPAD_ADDR_W-1:0] scpad_addr_t;
  typedef logic [SCPAD_DATA_W-1:0] scpad_data_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ISSUE,
    W_DRAIN,
    W_DONE
  } w_state_t;
endpackage

// File: rtl/w_outstanding_ctr.sv
// Up/down counter of in-flight bank writes, saturating at 0 and MAX_OUT.
//   clk, n_rst : clock, async active-low reset
//   inc        : one write accepted this cycle
//   dec        : one write acknowledged this cycle
//   count      : in-flight writes
//   full/empty : count == MAX_OUT / count == 0
module w_outstanding_ctr #(
  parameter  int MAX_OUT = 4,
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic inc_ok, dec_ok;

  assign full   = (count == CNT_W'(MAX_OUT));
  assign empty  = (count == '0);
  // An ack with nothing in flight is spurious and dropped.
  assign inc_ok = inc && !full;
  assign dec_ok = dec && !empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count <= '0;
    else if (inc_ok && !dec_ok)
      count <= count + CNT_W'(1);
    else if (dec_ok && !inc_ok)
      count <= count - CNT_W'(1);
  end
endmodule

// File: rtl/w_fsm.sv
// Scratchpad write-channel FSM.
// Takes one descriptor (base row, row count), streams rows from the write-data
// input into bank write requests, keeps at most MAX_OUT writes unacknowledged,
// and pulses done once every row has been acknowledged.
//   clk, n_rst                      : clock, async active-low reset
//   start, desc_valid, desc_addr,
//   desc_len                        : descriptor (sampled only while idle)
//   busy                            : transaction in progress
//   wdata_valid, wdata, wdata_ready : row stream; ready = row consumed
//   req_valid, req_ready, req_vc,
//   addr, req_wdata                 : bank write request
//   wack_valid                      : one bank write completed
//   done                            : one-cycle completion pulse
module w_fsm
  import scratchpad_types_pkg::*;
#(
  parameter int VC_ID   = 0,
  parameter int VC_W    = 1,
  parameter int ADDR_W  = SCPAD_ADDR_W,
  parameter int DATA_W  = SCPAD_DATA_W,
  parameter int LEN_W   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              desc_valid,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_len,
  output logic              busy,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [VC_W-1:0]   req_vc,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              wack_valid,
  output logic              done
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  w_state_t          state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  rows_left;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_full, out_empty;
  logic              accept, desc_take, drained;

  assign accept    = req_valid && req_ready;
  assign desc_take = (state == W_IDLE) && start && desc_valid;
  // Drain completes when nothing is in flight, or the last in-flight ack
  // lands this cycle (no new issues are possible while draining).
  assign drained   = out_empty || ((out_cnt == CNT_W'(1)) && wack_valid);

  w_outstanding_ctr #(.MAX_OUT(MAX_OUT)) u_out_ctr (
    .clk  (clk),
    .n_rst(n_rst),
    .inc  (accept),
    .dec  (wack_valid),
    .count(out_cnt),
    .full (out_full),
    .empty(out_empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= W_IDLE;
      cur_addr  <= '0;
      rows_left <= '0;
    end else begin
      state <= state_nxt;
      if (desc_take) begin
        cur_addr  <= desc_addr;
        rows_left <= desc_len;
      end else if (accept) begin
        cur_addr  <= cur_addr + ADDR_W'(1);  // wraps modulo 2^ADDR_W
        rows_left <= rows_left - LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    done      = 1'b0;
    case (state)
      W_IDLE: begin
        if (desc_take)
          state_nxt = (desc_len == '0) ? W_DONE : W_ISSUE;
      end
      W_ISSUE: begin
        // Full is registered, so an ack reopens issue only on the next cycle.
        req_valid = wdata_valid && !out_full;
        if (accept && (rows_left == LEN_W'(1)))
          state_nxt = W_DRAIN;
      end
      W_DRAIN: begin
        if (drained)
          state_nxt = W_DONE;
      end
      W_DONE: begin
        done      = 1'b1;
        state_nxt = W_IDLE;
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  assign busy        = (state != W_IDLE);
  assign wdata_ready = accept;
  assign req_vc      = VC_W'(VC_ID);
  assign addr        = cur_addr;
  assign req_wdata   = (state == W_ISSUE) ? wdata : '0;
endmodule

// File: tb/tb_w_fsm.sv
module tb_w_fsm;
  localparam int MAX_OUT = 4;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0, desc_valid = 1'b0;
  logic [15:0]  desc_addr = '0;
  logic [7:0]   desc_len = '0;
  logic         busy;
  logic         wdata_valid = 1'b0;
  logic [127:0] wdata = '0;
  logic         wdata_ready;
  logic         req_valid;
  logic         req_ready = 1'b0;
  logic [0:0]   req_vc;
  logic [15:0]  addr;
  logic [127:0] req_wdata;
  logic         wack_valid = 1'b0;
  logic         done;

  w_fsm #(.VC_ID(0), .VC_W(1), .ADDR_W(16), .DATA_W(128), .LEN_W(8), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .desc_valid(desc_valid),
    .desc_addr(desc_addr), .desc_len(desc_len), .busy(busy),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_vc(req_vc),
    .addr(addr), .req_wdata(req_wdata), .wack_valid(wack_valid), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  // Results of the last run_txn, for scenario-specific checks.
  logic [15:0] acc_addr_q[$];
  int          acc_cyc_q[$];
  int          due_q[$];
  int          g_s_cyc, g_done_cyc, g_done_cnt;

  // Transaction-level reference: the i-th accepted request must carry
  // base+i (16-bit wrap) and the i-th row; in-flight = accepted - acked never
  // exceeds MAX_OUT; a request is expected whenever rows remain and a slot is
  // free; done pulses once, the cycle after the last ack (or the cycle after
  // the descriptor for len 0).
  task automatic run_txn(input logic [15:0] a, input int len, input int rdy_pct,
                         input int lmin, input int lmax, input bit spam,
                         input logic [127:0] pat, input string nm);
    logic [127:0] exp_d[$];
    int accepted = 0, acked = 0, outst, last_ack = -1, k = 0, ai, exp_done;
    bit exp_rv, acc, fin = 0;
    logic [15:0] ea;
    acc_addr_q.delete(); acc_cyc_q.delete(); due_q.delete();
    g_done_cnt = 0; g_done_cyc = -1;
    for (int i = 0; i < len; i++)
      exp_d.push_back(pat != '0 ? pat : {$urandom(), $urandom(), $urandom(), $urandom()});

    @(posedge clk); #1;
    start = 1; desc_valid = 1; desc_addr = a; desc_len = 8'(len);
    wdata_valid = 0; req_ready = 0; wack_valid = 0;
    g_s_cyc = cyc;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || req_valid !== 1'b0) begin
      n_err++; $display("FAIL %s.idle busy=%b req_valid=%b exp 0/0", nm, busy, req_valid);
    end
    @(posedge clk); #1;
    while (!fin && k < 400) begin
      start = spam && (g_done_cnt == 0);
      desc_valid = start;
      desc_addr = 16'($urandom()); desc_len = 8'($urandom_range(1, 20));
      wdata_valid = (accepted < len);
      wdata = (accepted < len) ? exp_d[accepted] : {4{$urandom()}};
      req_ready = ($urandom_range(99) < rdy_pct);
      ai = -1;
      foreach (due_q[i]) if (due_q[i] <= cyc && (ai < 0 || due_q[i] < due_q[ai])) ai = i;
      wack_valid = (ai >= 0);
      if (ai >= 0) due_q.delete(ai);
      #1;
      fin = (g_done_cnt > 0);
      outst = accepted - acked;
      exp_rv = (accepted < len) && (outst < MAX_OUT) && !fin;
      n_cmp++;
      if (req_valid !== exp_rv) begin
        n_err++; $display("FAIL %s.req_valid cyc %0d got %b exp %b (acc %0d ack %0d)",
                          nm, cyc - g_s_cyc, req_valid, exp_rv, accepted, acked);
      end
      n_cmp++;
      if (busy !== !fin) begin
        n_err++; $display("FAIL %s.busy cyc %0d got %b exp %b", nm, cyc - g_s_cyc, busy, !fin);
      end
      acc = req_valid && req_ready;
      n_cmp++;
      if (wdata_ready !== acc) begin
        n_err++; $display("FAIL %s.wdata_ready got %b exp %b", nm, wdata_ready, acc);
      end
      if (acc && accepted < len) begin
        ea = a + 16'(accepted);
        n_cmp++;
        if (addr !== ea || req_wdata !== exp_d[accepted] || req_vc !== 1'b0) begin
          n_err++; $display("FAIL %s.req[%0d] addr %h data %h vc %b exp %h %h 0",
                            nm, accepted, addr, req_wdata, req_vc, ea, exp_d[accepted]);
        end
        acc_addr_q.push_back(addr); acc_cyc_q.push_back(cyc);
        due_q.push_back(cyc + $urandom_range(lmax, lmin));
        accepted++;
      end
      if (wack_valid) begin
        acked++;
        if (acked == len) last_ack = cyc;
      end
      if (done === 1'b1) begin g_done_cnt++; g_done_cyc = cyc; end
      else if (done !== 1'b0) begin
        n_err++; $display("FAIL %s.done got %b exp 0/1", nm, done);
      end
      if (!fin) begin @(posedge clk); #1; end
      k++;
    end
    start = 0; desc_valid = 0; wdata_valid = 0; req_ready = 0; wack_valid = 0;
    exp_done = (len == 0) ? g_s_cyc + 1 : last_ack + 1;
    n_cmp++;
    if (!fin) begin
      n_err++; $display("FAIL %s.timeout acc %0d ack %0d done %0d exp completion", nm, accepted, acked, g_done_cnt);
    end
    n_cmp++;
    if (g_done_cnt != 1 || g_done_cyc != exp_done || accepted != len) begin
      n_err++; $display("FAIL %s.done_pulse cnt %0d at %0d rows %0d exp 1 at %0d rows %0d",
                        nm, g_done_cnt, g_done_cyc - g_s_cyc, accepted, exp_done - g_s_cyc, len);
    end
  endtask

  task automatic test_reset();
    n_rst = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, req_valid, wdata_ready, done} !== 4'b0 || addr !== 16'h0 || req_wdata !== '0) begin
      n_err++; $display("FAIL reset busy/rv/wr/done %b addr %h data %h exp 0", {busy, req_valid, wdata_ready, done}, addr, req_wdata);
    end
    @(negedge clk) n_rst = 1;
  endtask

  task automatic test_one_row();
    run_txn(16'h0100, 1, 100, 3, 3, 0, {16{8'hA5}}, "one_row");
    n_cmp++;
    if (acc_cyc_q.size() != 1 || acc_addr_q[0] !== 16'h0100 || g_done_cyc != acc_cyc_q[0] + 4) begin
      n_err++; $display("FAIL one_row.timing reqs %0d done %0d exp 1 req, done 4 cycles after accept",
                        acc_cyc_q.size(), g_done_cyc - g_s_cyc);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(16'h0200, 4, 100, 1, 4, 0, '0, "b2b");
    n_cmp++;
    if (acc_cyc_q.size() != 4 || acc_cyc_q[3] != acc_cyc_q[0] + 3 || acc_cyc_q[0] != g_s_cyc + 1
        || acc_addr_q[3] !== 16'h0203) begin
      n_err++; $display("FAIL b2b.spacing reqs %0d exp 4 consecutive from start+1", acc_cyc_q.size());
    end
  endtask

  task automatic test_max_out();
    run_txn(16'h0400, 6, 100, 10, 10, 0, '0, "max_out");
    n_cmp++;
    if (acc_cyc_q.size() != 6 || acc_cyc_q[3] != acc_cyc_q[0] + 3 || acc_cyc_q[4] != acc_cyc_q[0] + 11) begin
      n_err++; $display("FAIL max_out.stall 5th req at +%0d exp +11",
                        acc_cyc_q.size() > 4 ? acc_cyc_q[4] - acc_cyc_q[0] : -1);
    end
  endtask

  task automatic test_zero_len();
    run_txn(16'h0500, 0, 100, 1, 1, 0, '0, "zero_len");
  endtask

  task automatic test_wrap();
    run_txn(16'hFFFE, 3, 100, 1, 3, 0, '0, "wrap");
    n_cmp++;
    if (acc_addr_q.size() != 3 || acc_addr_q[2] !== 16'h0000) begin
      n_err++; $display("FAIL wrap.addr third %h exp 0000", acc_addr_q.size() == 3 ? acc_addr_q[2] : 16'hxxxx);
    end
  endtask

  task automatic test_busy_start();
    run_txn(16'h0600, 5, 70, 1, 5, 1, '0, "busy_start");
  endtask

  task automatic test_reset_mid();
    int seen = 0, k = 0;
    @(posedge clk); #1;
    start = 1; desc_valid = 1; desc_addr = 16'h0300; desc_len = 8'd5;
    req_ready = 1; wack_valid = 0; wdata_valid = 1; wdata = {4{$urandom()}};
    @(posedge clk); #1;
    start = 0; desc_valid = 0;
    while (seen < 2 && k < 20) begin
      #1; if (req_valid) seen++;
      @(posedge clk); #1; k++;
    end
    n_rst = 0;
    #1;
    n_cmp++;
    if ({busy, req_valid, wdata_ready, done} !== 4'b0 || addr !== 16'h0 || req_wdata !== '0 || seen != 2) begin
      n_err++; $display("FAIL reset_mid.outputs %b addr %h sent %0d exp 0 0 2", {busy, req_valid, wdata_ready, done}, addr, seen);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL reset_mid.hold done %b busy %b exp 0 0", done, busy);
      end
    end
    wdata_valid = 0; req_ready = 0;
    @(negedge clk) n_rst = 1;
    run_txn(16'h0700, 3, 100, 1, 2, 0, '0, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++)
      run_txn(16'($urandom()), $urandom_range(12), $urandom_range(100, 40),
              1, $urandom_range(6, 1), 0, '0, "random");
  endtask

  initial begin
    test_reset();
    test_one_row();
    test_back_to_back();
    test_max_out();
    test_zero_len();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
